spi_bus_sequencer: RTL



---
 rtl/spi_bus_sequencer_pkg.sv | 28 ++
 rtl/spi_bus_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_sequencer_pkg.sv
// Shared definitions for spi_bus_sequencer: SPI core register map and sequencer states.
package spi_bus_sequencer_pkg;

    localparam int unsigned REG_START   = 1;
    localparam int unsigned REG_BITS_LO = 3;
    localparam int unsigned REG_BITS_HI = 4;
    localparam int unsigned MEM_OUT_OFF = 16;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_LOAD     = 4'd1,
        ST_DRAIN    = 4'd2,
        ST_CFG_LO   = 4'd3,
        ST_CFG_HI   = 4'd4,
        ST_START    = 4'd5,
        ST_POLL_RD  = 4'd6,
        ST_POLL_CHK = 4'd7,
        ST_RD_REQ   = 4'd8,
        ST_RD_CAP   = 4'd9,
        ST_OUT      = 4'd10
    } state_e;

    // Read-back memory follows the output memory in the SPI core's map.
    function automatic int unsigned mem_in_off(input int unsigned mem_bytes);
        return MEM_OUT_OFF + mem_bytes;
    endfunction

endpackage

// File: rtl/spi_bus_sequencer.sv
// Bus master that loads one command frame into the SPI core, starts it, polls DONE
// and streams the read-back bytes downstream.
module spi_bus_sequencer #(
    parameter int unsigned ABUSWIDTH = 16,
    parameter int unsigned MEM_BYTES = 16,
    parameter int unsigned BASEADDR  = 0,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [7:0]           CMD_DATA,
    input  logic                 CMD_VALID,
    input  logic                 CMD_LAST,
    output logic                 CMD_READY,
    output logic [7:0]           RES_DATA,
    output logic                 RES_VALID,
    output logic                 RES_LAST,
    input  logic                 RES_READY,
    output logic [ABUSWIDTH-1:0] M_ADD,
    output logic [7:0]           M_DATA_OUT,
    output logic                 M_WR,
    output logic                 M_RD,
    input  logic [7:0]           M_DATA_IN,
    output logic                 BUSY,
    output logic                 ERR_OVF,
    output logic                 ERR_TIMEOUT
);
    import spi_bus_sequencer_pkg::*;

    localparam int unsigned NW = $clog2(MEM_BYTES) + 1;
    localparam logic [NW-1:0] N_LAST = NW'(MEM_BYTES - 1);
    localparam logic [ABUSWIDTH-1:0] ADDR_START   = ABUSWIDTH'(BASEADDR + REG_START);
    localparam logic [ABUSWIDTH-1:0] ADDR_BITS_LO = ABUSWIDTH'(BASEADDR + REG_BITS_LO);
    localparam logic [ABUSWIDTH-1:0] ADDR_BITS_HI = ABUSWIDTH'(BASEADDR + REG_BITS_HI);
    localparam logic [ABUSWIDTH-1:0] ADDR_OUT     = ABUSWIDTH'(BASEADDR + MEM_OUT_OFF);
    localparam logic [ABUSWIDTH-1:0] ADDR_IN      = ABUSWIDTH'(BASEADDR + mem_in_off(MEM_BYTES));

    state_e                 state_q, state_d;
    logic [NW-1:0]          n_q, n_d, i_q, i_d;
    logic [31:0]            tmo_q, tmo_d;
    logic                   poll_ph_q, poll_ph_d;
    logic [ABUSWIDTH-1:0]   m_add_q, m_add_d;
    logic [7:0]             m_dout_q, m_dout_d;
    logic                   m_wr_q, m_wr_d, m_rd_q, m_rd_d;
    logic [7:0]             res_data_q, res_data_d;
    logic                   res_valid_q, res_valid_d, res_last_q, res_last_d;
    logic                   err_ovf_q, err_ovf_d, err_tmo_q, err_tmo_d;
    logic                   cmd_ready_s, cmd_fire_s;
    logic [15:0]            bits_s;
    logic [31:0]            tmo_inc_s;

    assign cmd_ready_s = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign cmd_fire_s  = CMD_VALID && cmd_ready_s;
    assign bits_s      = 16'(n_q) << 2'd3;
    assign tmo_inc_s   = (tmo_q == 32'hFFFF_FFFF) ? tmo_q : tmo_q + 32'd1;

    // Next-state and next-output decode; every bus access is registered one cycle later.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        i_d         = i_q;
        tmo_d       = tmo_q;
        poll_ph_d   = 1'b0;
        m_add_d     = m_add_q;
        m_dout_d    = m_dout_q;
        m_wr_d      = 1'b0;
        m_rd_d      = 1'b0;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        err_ovf_d   = 1'b0;
        err_tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    m_wr_d   = 1'b1;
                    m_add_d  = ADDR_OUT;
                    m_dout_d = CMD_DATA;
                    n_d      = NW'(1'b1);
                    state_d  = CMD_LAST ? ST_CFG_LO : ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cmd_fire_s) begin
                    m_wr_d   = 1'b1;
                    m_add_d  = ADDR_OUT + ABUSWIDTH'(n_q);
                    m_dout_d = CMD_DATA;
                    n_d      = n_q + NW'(1'b1);
                    if (CMD_LAST) begin
                        state_d = ST_CFG_LO;
                    end else if (n_q == N_LAST) begin
                        err_ovf_d = 1'b1;
                        state_d   = ST_DRAIN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cmd_fire_s && CMD_LAST) begin
                    state_d = ST_CFG_LO;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_CFG_LO: begin
                m_wr_d   = 1'b1;
                m_add_d  = ADDR_BITS_LO;
                m_dout_d = bits_s[7:0];
                state_d  = ST_CFG_HI;
            end
            ST_CFG_HI: begin
                m_wr_d   = 1'b1;
                m_add_d  = ADDR_BITS_HI;
                m_dout_d = bits_s[15:8];
                state_d  = ST_START;
            end
            ST_START: begin
                m_wr_d   = 1'b1;
                m_add_d  = ADDR_START;
                m_dout_d = 8'h00;
                tmo_d    = 32'd0;
                state_d  = ST_POLL_RD;
            end
            ST_POLL_RD: begin
                m_rd_d  = 1'b1;
                m_add_d = ADDR_START;
                tmo_d   = tmo_inc_s;
                state_d = ST_POLL_CHK;
            end
            ST_POLL_CHK: begin
                tmo_d = tmo_inc_s;
                // Read data lags the strobe by one cycle, so decide on the second cycle here.
                if (!poll_ph_q) begin
                    poll_ph_d = 1'b1;
                    state_d   = ST_POLL_CHK;
                end else if (M_DATA_IN[0]) begin
                    i_d     = '0;
                    m_rd_d  = 1'b1;
                    m_add_d = ADDR_IN;
                    state_d = ST_RD_REQ;
                end else if (tmo_q >= 32'(TIMEOUT)) begin
                    err_tmo_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_POLL_RD;
                end
            end
            ST_RD_REQ: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                res_data_d  = M_DATA_IN;
                res_valid_d = 1'b1;
                res_last_d  = (i_q == n_q - NW'(1'b1));
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (RES_READY) begin
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                    if (res_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        i_d     = i_q + NW'(1'b1);
                        m_rd_d  = 1'b1;
                        m_add_d = ADDR_IN + ABUSWIDTH'(i_q + NW'(1'b1));
                        state_d = ST_RD_REQ;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            i_q         <= '0;
            tmo_q       <= 32'd0;
            poll_ph_q   <= 1'b0;
            m_add_q     <= '0;
            m_dout_q    <= 8'h00;
            m_wr_q      <= 1'b0;
            m_rd_q      <= 1'b0;
            res_data_q  <= 8'h00;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            i_q         <= i_d;
            tmo_q       <= tmo_d;
            poll_ph_q   <= poll_ph_d;
            m_add_q     <= m_add_d;
            m_dout_q    <= m_dout_d;
            m_wr_q      <= m_wr_d;
            m_rd_q      <= m_rd_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            err_ovf_q   <= err_ovf_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    assign CMD_READY   = cmd_ready_s;
    assign BUSY        = (state_q != ST_IDLE);
    assign M_ADD       = m_add_q;
    assign M_DATA_OUT  = m_dout_q;
    assign M_WR        = m_wr_q;
    assign M_RD        = m_rd_q;
    assign RES_DATA    = res_data_q;
    assign RES_VALID   = res_valid_q;
    assign RES_LAST    = res_last_q;
    assign ERR_OVF     = err_ovf_q;
    assign ERR_TIMEOUT = err_tmo_q;

endmodule
